// File: rtl/or_test_sequencer.sv
// Sweeps every WIDTH-bit vector into an OR gate and checks its result against |data_o.
// Optional feature macro: STOP_ON_ERR_EN (end the sweep at the first mismatch).
module or_test_sequencer #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] data_o,
  input  logic             result_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] first_err_vec
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            mismatch;
  logic            last_vec;
  logic            finish;

  assign mismatch = (result_i != (|data_o));
  assign last_vec = &data_o;
  assign pass     = done && (err_cnt == '0);

`ifdef STOP_ON_ERR_EN
  assign finish = last_vec || mismatch;
`else
  assign finish = last_vec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      data_o        <= '0;
      err_cnt       <= '0;
      first_err_vec <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            data_o        <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            cnt_q         <= CntLoad;
            done          <= 1'b0;
            busy          <= 1'b1;
            state_q       <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) state_q <= StCheck;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        StCheck: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) first_err_vec <= data_o;
          end
          if (finish) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            data_o  <= data_o + 1'b1;
            cnt_q   <= CntLoad;
            state_q <= StSettle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
